seg_display_ctrl: RTL and testbench
===================================

# seg_display_ctrl

Parametrised multi-digit seven-segment display controller for the calculator datapath. It accepts a binary result from the ALU, signed or unsigned. It converts the result to BCD sequentially using shift-and-add-3, one bit per cycle, then formats it with leading-zero blanking, a minus sign and an overflow indication. It time-multiplexes the formatted digits onto a shared segment bus with one-hot digit enables. It replaces the fixed four-digit combinational encoder/driver chain between the ALU and the board display.

## Interface
- DIGITS, 4, number of physical digits (≥1); digit 0 is rightmost
- DATA_W, 8, width of the input value (≥2)
- REFRESH_DIV, 50000, clock cycles each digit stays enabled (≥1)
- SEG_ACTIVE_LOW, 1, 1: segment on = 0; 0: segment on = 1
- DIG_ACTIVE_LOW, 1, 1: enabled digit = 0 in trigger; 0: enabled = 1
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- value  in  DATA_W  binary number to display
- is_signed  in  1  treat value as two's complement; sampled with load
- load  in  1  one-cycle request to convert and display value
- busy  out  1  conversion in progress; load ignored while high
- overflow  out  1  last committed value did not fit in DIGITS
- segBits  out  7  segments {g,f,e,d,c,b,a}; bit 0 = a
- trigger  out  DIGITS  one-hot digit enable; bit i = digit i

## Operation
- FSM states: IDLE, CONV, FMT.
- IDLE: if load=1, capture value and is_signed, go to CONV. If is_signed and value[DATA_W-1]=1, set neg=1 and store magnitude = -value as DATA_W-bit unsigned, so the most-negative value is handled. Otherwise neg=0 and magnitude = value.
- CONV: DATA_W cycles, one double-dabble step each. Before each shift, add 3 to every BCD nibble ≥5. Then shift {bcd, magnitude} left by 1. BCD register holds NB = ceil(DATA_W/3) nibbles. Exit to FMT after step DATA_W.
- FMT, one cycle, computes:
  - m = index of the most significant non-zero nibble, with m = 0 if the value is 0.
  - needed = m+1+neg.
  - If needed > DIGITS: overflow=1 and every display digit = dash (g only).
  - Else: overflow=0. Digits 0..m show BCD nibbles. If neg, digit m+1 shows minus (g only). All higher digits are blank.
  - Display registers and overflow are committed atomically; return to IDLE.
- The display keeps showing the previous committed value for the whole of CONV/FMT.
- Zero displays a single "0" in digit 0. Negative zero cannot occur.
- Glyphs use standard patterns for 0–9. Blank = all segments off. Minus and dash = g only. Polarity is applied by SEG_ACTIVE_LOW at the output.
- Scan:
  - A divider counts 0..REFRESH_DIV-1.
  - On wrap, scan index advances i → i+1, and DIGITS-1 → 0.
  - trigger enables digit index only; segBits shows that digit's glyph.
  - Scan runs continuously and independently of the FSM.

## Timing
- Reset values, held while rst=1 and after the first rst edge:
  - FSM = IDLE, busy=0, overflow=0.
  - All display registers blank, scan index 0, divider 0.
  - segBits = all segments off.
  - trigger = all digits disabled.
- First cycle after rst deasserts: trigger enables digit 0 and segBits shows blank.
- segBits and trigger are registered and change on the same edge. No cycle ever has two digits enabled.
- load sampled at edge k (in IDLE): busy=1 from edge k. CONV steps occur at edges k+1..k+DATA_W. FMT commit occurs at edge k+DATA_W+1, when busy returns to 0 and overflow updates.
- busy is high for exactly DATA_W+1 cycles.
- Committed display reaches segBits at the next scan edge for the active digit, at most 1 cycle after commit for the currently enabled digit.
- A load asserted while busy=1 is dropped, not queued. A load in the same cycle busy falls to 0 is accepted.
- rst mid-conversion aborts: display goes blank and the aborted value is never shown.
- Each digit is enabled for exactly REFRESH_DIV cycles per frame. Frame = DIGITS*REFRESH_DIV cycles.

## Test plan
All scenarios use DIGITS=4, DATA_W=8, REFRESH_DIV=4, active-low segments and active-low digits unless stated otherwise.
- Unsigned 200: load 8'd200, is_signed=0 -> busy high 9 cycles, then overflow=0. Digits 3..0 = blank,'2','0','0'. With trigger=4'b1110, segBits=7'b1000000; with trigger=4'b1011, segBits=7'b0100100; with trigger=4'b0111, segBits=7'b1111111.
- Signed negatives:
  - 8'hF6 (-10), is_signed=1 -> digits blank,'-','1','0'; digit 2 segBits=7'b0111111.
  - 8'h80 (-128) -> digits '-','1','2','8'.
  - 8'hF6 with is_signed=0 -> digits '2','4','6', i.e. 246.
- Overflow (DIGITS=2): load unsigned 200 -> overflow=1 and both digits show 7'b0111111. Signed -10 -> overflow=1. Unsigned 99 -> overflow=0, showing '9','9'.
- Busy/ignore: load 5, then load 7 three cycles later -> only 5 is displayed. A load of 7 in the cycle busy falls -> 7 is displayed after another 9 busy cycles. Old value remains visible during conversion.
- Scan: over 32 cycles, trigger sequence is 1110,1101,1011,0111, each held 4 cycles, repeating. No cycle has more than one zero bit.
- Reset: assert rst 4 cycles into a conversion of 8'd123 -> busy=0, overflow=0, trigger=4'b1111 during rst. After release, all digits are blank and 123 never appears. Then load 0 -> digit 0 shows 7'b1000000 and digits 1–3 are blank.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - multi-digit seven-segment controller with sequential binary-to-BCD
// Converts a signed/unsigned value by double-dabble, formats it with blanking/sign/overflow, and scans it out.
module seg_display_ctrl #(
  parameter int DIGITS         = 4,
  parameter int DATA_W         = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              is_signed,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        segBits,
  output logic [DIGITS-1:0] trigger
);

  localparam int NB   = (DATA_W + 2) / 3;
  localparam int BW   = 4 * NB;
  localparam int CW   = $clog2(DATA_W + 1);
  localparam int DIVW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0]        G_BLANK = 7'h00;
  localparam logic [6:0]        G_DASH  = 7'h40;
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [DATA_W-1:0] ONE_W   = 1;

  typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;

  state_t              state_q;
  logic                busy_q;
  logic                neg_q;
  logic                overflow_q;
  logic [DATA_W-1:0]   mag_q;
  logic [DATA_W-1:0]   mag_d;
  logic [BW-1:0]       bcd_q;
  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_d;
  logic [CW-1:0]       step_q;
  logic [6:0]          disp_q [DIGITS];
  logic [6:0]          disp_d [DIGITS];
  logic                ovf_d;
  logic [DIVW-1:0]     div_q;
  logic [SCW-1:0]      scan_q;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   trig_q;
  logic [DIGITS-1:0]   onehot;
  int                  msd;
  int                  needed;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = G_BLANK;
    endcase
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift the magnitude MSB in.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = (bcd_adj << 1) | BW'(mag_q[DATA_W-1]);
    mag_d = {mag_q[DATA_W-2:0], 1'b0};
  end

  always_comb begin
    msd = 0;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    needed = msd + 1 + (neg_q ? 1 : 0);
    ovf_d  = (needed > DIGITS);
    for (int d = 0; d < DIGITS; d++) begin
      disp_d[d] = G_BLANK;
      if (ovf_d) begin
        disp_d[d] = G_DASH;
      end else if (d < NB && d <= msd) begin
        disp_d[d] = glyph(bcd_q[4*(d % NB) +: 4]);
      end else if (neg_q && d == msd + 1) begin
        disp_d[d] = G_DASH;
      end
    end
  end

  always_comb begin
    onehot         = '0;
    onehot[scan_q] = 1'b1;
  end

  // Output registers follow the scan index of the current cycle, so each digit gets a full REFRESH_DIV window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      neg_q      <= 1'b0;
      overflow_q <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      for (int d = 0; d < DIGITS; d++) disp_q[d] <= G_BLANK;
      div_q      <= '0;
      scan_q     <= '0;
      seg_q      <= SEG_OFF;
      trig_q     <= DIG_OFF;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            neg_q   <= is_signed & value[DATA_W-1];
            mag_q   <= (is_signed & value[DATA_W-1]) ? (~value + ONE_W) : value;
            bcd_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q  <= bcd_d;
          mag_q  <= mag_d;
          step_q <= step_q + CW'(1);
          if (step_q == CW'(DATA_W - 1)) state_q <= FMT;
        end
        FMT: begin
          disp_q     <= disp_d;
          overflow_q <= ovf_d;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (div_q == DIVW'(REFRESH_DIV - 1)) begin
        div_q  <= '0;
        scan_q <= (scan_q == SCW'(DIGITS - 1)) ? '0 : scan_q + SCW'(1);
      end else begin
        div_q  <= div_q + DIVW'(1);
      end

      seg_q  <= SEG_ACTIVE_LOW ? ~disp_q[scan_q] : disp_q[scan_q];
      trig_q <= DIG_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign segBits  = seg_q;
  assign trigger  = trig_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - randomized self-checking bench for seg_display_ctrl
// Drives a 4-digit and a 2-digit instance in lockstep and compares against a decimal reference model.
module tb_seg_display_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic       is_signed;
  logic       load;
  logic       busy_a, ovf_a, busy_b, ovf_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] trig_a;
  logic [1:0] trig_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [6:0] exp_a [4];
  logic [6:0] exp_b [2];
  logic       exp_ovf_a, exp_ovf_b;

  seg_display_ctrl #(.DIGITS(4), .DATA_W(8), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .value(value), .is_signed(is_signed), .load(load),
    .busy(busy_a), .overflow(ovf_a), .segBits(seg_a), .trigger(trig_a)
  );

  seg_display_ctrl #(.DIGITS(2), .DATA_W(8), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .value(value), .is_signed(is_signed), .load(load),
    .busy(busy_b), .overflow(ovf_b), .segBits(seg_b), .trigger(trig_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'b0111111;  1: glyph = 7'b0000110;
      2: glyph = 7'b1011011;  3: glyph = 7'b1001111;
      4: glyph = 7'b1100110;  5: glyph = 7'b1101101;
      6: glyph = 7'b1111101;  7: glyph = 7'b0000111;
      8: glyph = 7'b1111111;  9: glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  function automatic int mag_of(input logic [7:0] v, input bit s);
    return (s && v[7]) ? 256 - int'(v) : int'(v);
  endfunction

  function automatic int ndec(input int m);
    int n = 1;
    while (m >= 10) begin
      m = m / 10;
      n++;
    end
    return n;
  endfunction

  function automatic bit ref_ovf(input logic [7:0] v, input bit s, input int nd);
    return (ndec(mag_of(v, s)) + ((s && v[7]) ? 1 : 0)) > nd;
  endfunction

  function automatic logic [6:0] ref_glyph(input logic [7:0] v, input bit s, input int nd, input int d);
    int m = mag_of(v, s);
    int p = 1;
    bit neg = s && v[7];
    if (ref_ovf(v, s, nd)) return 7'h40;
    for (int k = 0; k < d; k++) p = p * 10;
    if (d < ndec(m)) return glyph((m / p) % 10);
    if (neg && d == ndec(m)) return 7'h40;
    return 7'h00;
  endfunction

  task automatic set_model(input logic [7:0] v, input bit s);
    for (int d = 0; d < 4; d++) exp_a[d] = ref_glyph(v, s, 4, d);
    for (int d = 0; d < 2; d++) exp_b[d] = ref_glyph(v, s, 2, d);
    exp_ovf_a = ref_ovf(v, s, 4);
    exp_ovf_b = ref_ovf(v, s, 2);
  endtask

  task automatic set_blank();
    for (int d = 0; d < 4; d++) exp_a[d] = 7'h00;
    for (int d = 0; d < 2; d++) exp_b[d] = 7'h00;
    exp_ovf_a = 1'b0;
    exp_ovf_b = 1'b0;
  endtask

  task automatic sample_cycle();
    int ia, ib;
    logic [3:0] ta;
    logic [1:0] tb2;
    logic [6:0] sa, sb;
    ia  = ((cyc - 1) / 4) % 4;
    ib  = ((cyc - 1) / 4) % 2;
    ta  = ~(4'b0001 << ia);
    tb2 = ~(2'b01 << ib);
    sa  = ~exp_a[ia];
    sb  = ~exp_b[ib];
    check("trig_a", trig_a, ta);
    check("seg_a", seg_a, sa);
    check("trig_b", trig_b, tb2);
    check("seg_b", seg_b, sb);
  endtask

  task automatic check_display();
    @(negedge clk);
    repeat (32) begin
      sample_cycle();
      @(negedge clk);
    end
  endtask

  task automatic start_load(input logic [7:0] v, input bit s);
    value     = v;
    is_signed = s;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic wait_idle(input bit chk_old, output int n);
    n = 0;
    while (busy_a && n < 40) begin
      if (chk_old) sample_cycle();
      n++;
      @(negedge clk);
    end
    check("busy_b_idle", busy_b, 1'b0);
  endtask

  task automatic run(input logic [7:0] v, input bit s);
    int n;
    start_load(v, s);
    wait_idle(1'b1, n);
    check("busy_len", n, 9);
    set_model(v, s);
    check("ovf_a", ovf_a, exp_ovf_a);
    check("ovf_b", ovf_b, exp_ovf_b);
    check_display();
  endtask

  task automatic check_reset_outputs();
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_ovf_a", ovf_a, 1'b0);
    check("rst_trig_a", trig_a, 4'hf);
    check("rst_seg_a", seg_a, 7'h7f);
    check("rst_trig_b", trig_b, 2'h3);
    check("rst_seg_b", seg_b, 7'h7f);
  endtask

  initial begin
    int n;
    rst = 1'b1; load = 1'b0; value = '0; is_signed = 1'b0;
    set_blank();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    sample_cycle();
    check_display();

    run(8'd200, 1'b0);
    run(8'hF6, 1'b1);
    run(8'h80, 1'b1);
    run(8'hF6, 1'b0);
    run(8'd99, 1'b0);
    run(8'd0, 1'b0);

    start_load(8'd5, 1'b0);
    repeat (2) @(negedge clk);
    start_load(8'd7, 1'b0);
    wait_idle(1'b1, n);
    check("drop_busy_len", n, 6);
    set_model(8'd5, 1'b0);
    check("drop_ovf_a", ovf_a, exp_ovf_a);
    start_load(8'd7, 1'b0);
    wait_idle(1'b1, n);
    check("edge_busy_len", n, 9);
    set_model(8'd7, 1'b0);
    check_display();

    repeat (25) begin
      run(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    start_load(8'd123, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst = 1'b0;
    set_blank();
    @(negedge clk);
    sample_cycle();
    check_display();
    check("post_rst_busy", busy_a, 1'b0);
    check("post_rst_ovf", ovf_a, 1'b0);
    run(8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
